// File: rtl/fft4_pkg.sv
// Shared constants and types for the 4-point FFT datapath.
package fft4_pkg;

    localparam int DATA_W   = 4;
    localparam int N_POINTS = 4;
    localparam int IDX_W    = 2;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(N_POINTS - 1);

endpackage

// File: rtl/fft4_frame_bank.sv
// One N_POINTS x DATA_W sample bank; a closing write also zeroes every slot above idx.
module fft4_frame_bank
    import fft4_pkg::*;
#(
    parameter int DATA_W = fft4_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic                         fill,
    input  idx_t                         idx,
    input  logic [DATA_W-1:0]            din,
    output logic [N_POINTS*DATA_W-1:0]   q
);

    logic [DATA_W-1:0] mem [N_POINTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_POINTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < N_POINTS; i++) begin
                if (i == int'(idx)) begin
                    mem[i] <= din;
                end else if (fill && (i > int'(idx))) begin
                    mem[i] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < N_POINTS; g++) begin : g_out
        assign q[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/fft4_frame_loader.sv
// Serial-to-parallel frame loader with ping-pong banks feeding the 4-point FFT.
module fft4_frame_loader
    import fft4_pkg::*;
#(
    parameter int DATA_W = fft4_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] x_0,
    output logic [DATA_W-1:0] x_1,
    output logic [DATA_W-1:0] x_2,
    output logic [DATA_W-1:0] x_3,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              short_frame
);

    logic [1:0]                 full;
    logic [1:0]                 full_next;
    logic                       wr_bank;
    logic                       rd_bank;
    idx_t                       wr_idx;
    logic                       short_q;
    logic                       accept;
    logic                       close;
    logic                       consume;
    logic [N_POINTS*DATA_W-1:0] bank_q0;
    logic [N_POINTS*DATA_W-1:0] bank_q1;
    logic [N_POINTS*DATA_W-1:0] rd_q;

    assign s_ready     = !full[wr_bank];
    assign frame_valid = full[rd_bank];
    assign short_frame = short_q;

    assign accept  = s_valid && s_ready;
    assign close   = accept && ((wr_idx == LAST_IDX) || s_last);
    assign consume = frame_valid && frame_ready;

    fft4_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && !wr_bank),
        .fill  (close),
        .idx   (wr_idx),
        .din   (s_data),
        .q     (bank_q0)
    );

    fft4_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept && wr_bank),
        .fill  (close),
        .idx   (wr_idx),
        .din   (s_data),
        .q     (bank_q1)
    );

    assign rd_q = rd_bank ? bank_q1 : bank_q0;
    assign x_0  = rd_q[0*DATA_W +: DATA_W];
    assign x_1  = rd_q[1*DATA_W +: DATA_W];
    assign x_2  = rd_q[2*DATA_W +: DATA_W];
    assign x_3  = rd_q[3*DATA_W +: DATA_W];

    // Close and consume can never target the same bank: close needs it empty, consume needs it full.
    always_comb begin
        full_next = full;
        if (close) begin
            full_next[wr_bank] = 1'b1;
        end
        if (consume) begin
            full_next[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            short_q <= 1'b0;
        end else begin
            full    <= full_next;
            short_q <= close && (wr_idx != LAST_IDX);
            if (accept) begin
                if (close) begin
                    wr_idx  <= '0;
                    wr_bank <= !wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (consume) begin
                rd_bank <= !rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Directed and random-stall bench for fft4_frame_loader with a frame scoreboard.
module tb_fft4_frame_loader;

    localparam int DW = fft4_pkg::DATA_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic [DW-1:0] x_0, x_1, x_2, x_3;
    logic          frame_valid;
    logic          frame_ready;
    logic          short_frame;

    int n_cmp = 0;
    int n_err = 0;

    logic [4*DW-1:0] sb [$];
    logic [DW-1:0]   part [4];
    int              m_idx = 0;

    always #5 clk = ~clk;

    fft4_frame_loader #(.DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .x_0         (x_0),
        .x_1         (x_1),
        .x_2         (x_2),
        .x_3         (x_3),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .short_frame (short_frame)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the model, advance model with the edge.
    task automatic step(output bit acc);
        bit            cons;
        bit            exp_short;
        logic [DW-1:0] d;
        bit            l;
        chk("s_ready", s_ready, sb.size() < 2);
        chk("frame_valid", frame_valid, sb.size() > 0);
        if (sb.size() > 0) begin
            chk("frame", {x_0, x_1, x_2, x_3}, sb[0]);
        end
        acc       = s_valid && s_ready;
        cons      = frame_valid && frame_ready;
        d         = s_data;
        l         = s_last;
        exp_short = 1'b0;
        @(posedge clk);
        if (cons && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (acc) begin
            part[m_idx] = d;
            if (m_idx == 3 || l) begin
                for (int i = m_idx + 1; i < 4; i++) part[i] = '0;
                sb.push_back({part[0], part[1], part[2], part[3]});
                exp_short = (m_idx != 3);
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        #1;
        chk("short_frame", short_frame, exp_short);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last);
        bit acc = 1'b0;
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!acc && n < 100) begin
            step(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_x", {x_0, x_1, x_2, x_3}, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_short_frame", short_frame, 0);
        sb.delete();
        m_idx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int n_acc;
        int cyc;
        rst_n       = 1'b0;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();
        idle(1);

        // Reset mid-frame, then a clean frame with no stale data.
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        apply_reset();
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        idle(2);
        chk("reset_frame", {x_0, x_1, x_2, x_3}, 16'h1234);
        frame_ready = 1'b1;
        idle(2);

        // Back-to-back frame with downstream always ready.
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        send(4'd7, 1'b0);
        send(4'd1, 1'b0);
        idle(3);

        // Backpressure: two full banks stall the ninth sample.
        frame_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(DW'(i), 1'b0);
        s_valid = 1'b1;
        s_data  = 4'd9;
        idle(3);
        chk("stall_s_ready", s_ready, 0);
        frame_ready = 1'b1;
        send(4'd9, 1'b0);

        // Short frames and a full-length s_last frame.
        send(4'd2, 1'b1);
        idle(2);
        send(4'd6, 1'b1);
        idle(2);
        send(4'd10, 1'b0);
        send(4'd11, 1'b0);
        send(4'd12, 1'b0);
        send(4'd13, 1'b1);
        idle(2);

        // Close B on the same edge that consumes A.
        frame_ready = 1'b0;
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        send(4'd4, 1'b0);
        send(4'd5, 1'b0);
        send(4'd6, 1'b0);
        send(4'd7, 1'b0);
        frame_ready = 1'b1;
        send(4'd8, 1'b0);
        frame_ready = 1'b0;
        chk("no_bubble_valid", frame_valid, 1);
        chk("no_bubble_x", {x_0, x_1, x_2, x_3}, 16'h5678);
        idle(2);
        frame_ready = 1'b1;
        idle(2);

        // Random stalls on both sides.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            s_valid     = ($urandom_range(0, 3) != 0);
            s_data      = DW'($urandom);
            s_last      = ($urandom_range(0, 5) == 0);
            frame_ready = ($urandom_range(0, 2) != 0);
            step(acc);
            if (acc) n_acc++;
            cyc++;
        end
        chk("stress_done", n_acc, 1000);
        s_valid     = 1'b0;
        s_last      = 1'b0;
        frame_ready = 1'b1;
        idle(4);
        chk("drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
